// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian byte pairs into 16-bit instruction-memory writes
// and holds the CPU fetch path stalled while a load session runs.
module imem_loader #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [INST_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              cpu_stall_o,
  output logic              done_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LO    = 3'd1;
  localparam logic [2:0] HI    = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last;
  logic [7:0]        lo;
  logic [ADDR_W-1:0] last_n;
  // Only the last word index is kept; zero or oversized lengths fill the whole memory.
  always_comb begin
    last_n = (len_i == '0 || len_i > DEPTH) ? '1 : ADDR_W'(len_i - 1'b1);
    byte_ready_o = state == LO || state == HI;
    wr_en_o = state == WRITE;
    busy_o = state == LO || state == HI || state == WRITE;
    cpu_stall_o = busy_o;
    done_o = state == DONE;
  end
  // The write port registers are loaded with the high byte so they are valid in WRITE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      last <= '0;
      lo <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          cnt <= '0;
          last <= last_n;
          state <= LO;
        end
        LO: if (byte_valid_i) begin
          lo <= byte_i;
          state <= HI;
        end
        HI: if (byte_valid_i) begin
          wr_addr_o <= cnt;
          wr_data_o <= {byte_i, lo};
          state <= WRITE;
        end
        WRITE: if (cnt == last) state <= DONE;
        else begin
          cnt <= cnt + 1'b1;
          state <= LO;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
